credit_tx: RTL and testbench
============================

Name: credit_tx

Overview:
- Transmit-side partner of the team's ready/valid FIFO when that FIFO sits across a registered link or pipeline boundary and cannot drive a combinational ready back.
- Accepts entries from an upstream producer over ready/valid and forwards them one cycle later as a registered valid/data pulse.
- Counts free entries in the remote FIFO with a credit counter and never sends more entries than the remote FIFO can hold.
- The remote end returns one credit per cycle, one for each entry it dequeues.

Parameters:
- ENTRY_WIDTH, 32, width of each data entry.
- N_CREDITS, 8, depth of the remote FIFO; also the initial credit count.
- CTR_WIDTH (localparam), $clog2(N_CREDITS+1), credit counter width; holds 0..N_CREDITS inclusive.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_ready  out  1  transmitter can accept an entry this cycle.
- in_valid  in  1  producer offers an entry.
- in_data  in  ENTRY_WIDTH  offered entry.
- out_valid  out  1  registered pulse: one entry is being delivered to the remote FIFO.
- out_data  out  ENTRY_WIDTH  registered entry; meaningful only while out_valid=1.
- credit_return  in  1  remote FIFO dequeued one entry last cycle (one credit per asserted cycle).
- credits  out  CTR_WIDTH  current credit count (debug/verification).
- idle  out  1  credits==N_CREDITS and out_valid==0.
- err_overflow  out  1  sticky: a credit was returned while credits was already N_CREDITS.

Behaviour:
- Single clock domain. All state updates on posedge clk. rst is synchronous, active-high.
- Reset values (when rst=1 at a posedge): credits=N_CREDITS, out_valid=0, out_data=0, err_overflow=0. On the cycle after, in_ready=1 and idle=1.
- in_ready = (credits != 0). Decoded from the credits register only; no combinational path from in_valid or credit_return.
- send = in_valid & in_ready.
- Data path, latency 1:
  - out_valid_next = send.
  - out_data loads in_data when send=1 and holds otherwise.
  - The remote side applies no backpressure; credits guarantee space.
- Credit counter update, per cycle:
  - send=1, return=0: credits-1.
  - send=0, return=1: credits+1.
  - both: unchanged (legal at any credit value where send is possible).
  - neither: unchanged.
- Boundary at credits=0: in_ready=0, so send cannot occur. A return moves credits to 1, and in_ready rises the following cycle (1-cycle return-to-ready latency).
- Boundary at credits=N_CREDITS:
  - return with send=0 is a protocol violation: credits holds at N_CREDITS (saturate, no wrap) and err_overflow sets and stays set until rst.
  - return with send=1 is legal: credits stays at N_CREDITS.
- Throughput: back-to-back accepts every cycle while credits>0. Steady-state full rate requires the remote round-trip to be no longer than N_CREDITS cycles.
- Reset mid-operation: in-flight out_valid is dropped and all credits are restored. The remote FIFO must be reset in the same cycle; the bench treats the two as one reset domain.
- Producer may drop or change in_valid/in_data while in_ready=0; no stickiness is required.

Decomposition:
- Shared package: ENTRY_WIDTH default, a CREDIT_CTR_WIDTH(depth) helper constant/function.
- Sub-module up_down_counter:
  - parameters WIDTH, MAX, RESET_VAL.
  - inputs inc, dec; outputs count, sat_err.
  - synchronous active-high reset.
  - saturates at MAX (sets sat_err) and at 0.
- Data and valid registers are built from the existing register primitive with write-enable.

Test Plan:
- Reset: assert rst 2 cycles -> credits=8, in_ready=1, out_valid=0, out_data=0, idle=1, err_overflow=0.
- Fill: in_valid=1 with data 0x10..0x17 for 8 cycles, no returns -> out_valid pulses carry 0x10..0x17 each one cycle after accept; credits reaches 0; in_ready=0; 9th entry 0x18 held, not sent.
- Credit return at zero: credit_return=1 for 1 cycle at credits=0 -> credits=1, in_ready=1 next cycle, 0x18 accepted then, and out_valid/0x18 the cycle after.
- Simultaneous send and return at credits=3 for 5 cycles -> credits stays 3, one out_valid per cycle, data in order.
- Overflow: at credits=8, idle, credit_return=1 -> credits stays 8, err_overflow=1 and remains 1 until rst.
- Mid-op reset: at credits=2 with out_valid=1, assert rst -> next cycle out_valid=0, credits=8, err_overflow=0.

Source files
------------

// File: rtl/credit_tx_pkg.sv
// Shared constants and helpers for the credit-based transmitter.
package credit_tx_pkg;

  // Default width of one data entry.
  localparam int ENTRY_WIDTH_DEFAULT = 32;

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int credit_ctr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_tx_dff_en.sv
// Register primitive with write-enable and synchronous active-high reset.
module dff_en #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Load d when enabled, otherwise hold; reset to RESET_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/credit_tx_up_down_counter.sv
// Saturating up/down counter with a sticky over-range flag.
// inc and dec in the same cycle cancel and leave the count unchanged.
module up_down_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 8,
  parameter int RESET_VAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat_err
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             sat_err_r;
  logic             sat_err_nxt_s;

  // Next count: step by one, clamp at MAX (flagging it) and at zero.
  always_comb begin
    count_nxt_s   = count_r;
    sat_err_nxt_s = sat_err_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r == MAX_V) begin
          count_nxt_s   = count_r;
          sat_err_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + ONE_V;
        end
      end
      2'b01: begin
        if (count_r != ZERO_V) begin
          count_nxt_s = count_r - ONE_V;
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Count and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= RST_V;
      sat_err_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      sat_err_r <= sat_err_nxt_s;
    end
  end

  assign count   = count_r;
  assign sat_err = sat_err_r;

endmodule

// File: rtl/credit_tx.sv
// Credit-based transmitter: accepts entries over ready/valid and forwards
// them one cycle later, never sending more than the remote FIFO can hold.
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int ENTRY_WIDTH = ENTRY_WIDTH_DEFAULT,
  parameter int N_CREDITS   = 8,
  localparam int CTR_WIDTH  = credit_ctr_width(N_CREDITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [ENTRY_WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [ENTRY_WIDTH-1:0] out_data,
  input  logic                   credit_return,
  output logic [CTR_WIDTH-1:0]   credits,
  output logic                   idle,
  output logic                   err_overflow
);

  localparam logic [CTR_WIDTH-1:0] FULL_V = CTR_WIDTH'(N_CREDITS);
  localparam logic [CTR_WIDTH-1:0] ZERO_V = {CTR_WIDTH{1'b0}};

  logic send_s;

  // Ready depends only on the credit register, so the upstream never sees
  // a combinational path from in_valid or credit_return.
  assign in_ready = (credits != ZERO_V);
  assign send_s   = in_valid & in_ready;
  assign idle     = (credits == FULL_V) & ~out_valid;

  // Free-slot count of the remote FIFO: send consumes, return refunds.
  up_down_counter #(
    .WIDTH     (CTR_WIDTH),
    .MAX       (N_CREDITS),
    .RESET_VAL (N_CREDITS)
  ) u_credit_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc     (credit_return),
    .dec     (send_s),
    .count   (credits),
    .sat_err (err_overflow)
  );

  // One-cycle valid pulse per accepted entry.
  dff_en #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_valid_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (send_s),
    .q   (out_valid)
  );

  // Data register loads only on accept and holds otherwise.
  dff_en #(
    .WIDTH     (ENTRY_WIDTH),
    .RESET_VAL ({ENTRY_WIDTH{1'b0}})
  ) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (send_s),
    .d   (in_data),
    .q   (out_data)
  );

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: directed table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_credit_tx;

  localparam int EW = 32;
  localparam int NC = 8;
  localparam int CW = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_ready;
  logic          in_valid;
  logic [EW-1:0] in_data;
  logic          out_valid;
  logic [EW-1:0] out_data;
  logic          credit_return;
  logic [CW-1:0] credits;
  logic          idle;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int            m_cr;
  logic          m_ov;
  logic [EW-1:0] m_od;
  logic          m_err;

  always #5 clk = ~clk;

  credit_tx #(.ENTRY_WIDTH(EW), .N_CREDITS(NC)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_ready      (in_ready),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .credit_return (credit_return),
    .credits       (credits),
    .idle          (idle),
    .err_overflow  (err_overflow)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       ret;
    int         cr;
    logic       ov;
    logic [7:0] od;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic ret,
                     input int cr, input logic ov, input logic [7:0] od, input logic err);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.ret = ret;
    x.cr = cr; x.ov = ov; x.od = od; x.err = err;
    vecs.push_back(x);
  endtask

  // Advance one clock and update the model from the spec's rules.
  task automatic tick();
    logic snd;
    int   nxt;
    snd = in_valid && (m_cr > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cr = NC; m_ov = 1'b0; m_od = '0; m_err = 1'b0;
    end else begin
      m_ov = snd;
      if (snd) m_od = in_data;
      nxt = m_cr - (snd ? 1 : 0) + (credit_return ? 1 : 0);
      if (nxt > NC) begin
        nxt   = NC;
        m_err = 1'b1;
      end
      m_cr = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " credits"},   64'(credits),      64'(m_cr));
    chk({tag, " in_ready"},  64'(in_ready),     64'(m_cr > 0));
    chk({tag, " out_valid"}, 64'(out_valid),    64'(m_ov));
    chk({tag, " out_data"},  64'(out_data),     64'(m_od));
    chk({tag, " err"},       64'(err_overflow), 64'(m_err));
    chk({tag, " idle"},      64'(idle),         64'((m_cr == NC) && !m_ov));
  endtask

  task automatic drive(input logic r, input logic v, input logic [EW-1:0] d, input logic ret);
    rst = r; in_valid = v; in_data = d; credit_return = ret;
  endtask

  initial begin
    m_cr = NC; m_ov = 1'b0; m_od = '0; m_err = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0);

    // Directed table: each row is one cycle; expectations are after the edge.
    add(1, 0, 8'h00, 0, 8, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 8, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 8'(8'h10 + i), 0, 7 - i, 1, 8'(8'h10 + i), 0);
    add(0, 1, 8'h18, 0, 0, 0, 8'h17, 0);   // held at zero credits
    add(0, 1, 8'h18, 1, 1, 0, 8'h17, 0);   // return at zero: ready next cycle
    add(0, 1, 8'h18, 0, 0, 1, 8'h18, 0);   // 0x18 accepted
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, i + 1, 0, 8'h18, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 8'(8'h20 + i), 1, 3, 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 1, 4 + i, 0, 8'h24, 0);
    add(0, 0, 8'h00, 1, 8, 0, 8'h24, 1);   // overflow
    add(0, 0, 8'h00, 0, 8, 0, 8'h24, 1);   // sticky
    add(0, 1, 8'h30, 1, 8, 1, 8'h30, 1);   // send+return at full is legal
    add(1, 0, 8'h00, 0, 8, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 8'(8'h40 + i), 0, 7 - i, 1, 8'(8'h40 + i), 0);
    add(1, 1, 8'h46, 0, 8, 0, 8'h00, 0);   // mid-operation reset

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, EW'(vecs[i].d), vecs[i].ret);
      tick();
      chk($sformatf("vec%0d credits", i),   64'(credits),      64'(vecs[i].cr));
      chk($sformatf("vec%0d in_ready", i),  64'(in_ready),     64'(vecs[i].cr != 0));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid),    64'(vecs[i].ov));
      chk($sformatf("vec%0d out_data", i),  64'(out_data),     64'(vecs[i].od));
      chk($sformatf("vec%0d err", i),       64'(err_overflow), 64'(vecs[i].err));
      chk($sformatf("vec%0d idle", i),      64'(idle),         64'((vecs[i].cr == NC) && !vecs[i].ov));
    end

    // Hand sequence: in_ready must not react combinationally to credit_return.
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    for (int i = 0; i < NC; i++) begin
      drive(1'b0, 1'b1, EW'(32'h100 + i), 1'b0);
      tick();
    end
    check_model("drain");
    drive(1'b0, 1'b1, 32'h0000_0ABC, 1'b1);
    #1;
    chk("ready_no_comb_path", 64'(in_ready), 64'(1'b0));
    tick();
    check_model("ret_at_zero");
    chk("ret_at_zero not_sent", 64'(out_valid), 64'(1'b0));
    drive(1'b0, 1'b1, 32'h0000_0ABC, 1'b0);
    tick();
    check_model("accept_after_ret");
    chk("accept_after_ret data", 64'(out_data), 64'(32'h0000_0ABC));

    // Randomized traffic against the model.
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic r_ret;
      if (m_cr < NC) r_ret = ($urandom_range(0, 1) == 1);
      else           r_ret = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), EW'($urandom), r_ret);
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
